// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a selectable read mode.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   rst_n        synchronous active-low reset
//   wr_en        write request, wr_data the word to write
//   rd_en        read request (FWFT: pop the head word)
//   rd_data      read data; rd_valid marks it as holding a valid word
//   full/empty   count == DEPTH / count == 0
//   almost_full  count >= AF_THRESH
//   almost_empty count <= AE_THRESH
//   count        current occupancy, 0..DEPTH
//   overflow     sticky, a write was rejected
//   underflow    sticky, a read was rejected
//   clr_err      clears overflow/underflow (a same-cycle new error wins)
module sync_fifo_flags #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2,
    parameter int unsigned FWFT      = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          rd_acc, wr_acc;

    // Flags are pure decodes of the registered count.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        rd_acc      = rd_en && !empty;
        // A full FIFO still accepts a write when a read frees a slot this cycle.
        wr_acc      = wr_en && (!full || rd_acc);
        wr_ptr_d    = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d     = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Set has priority over clear.
        overflow_d  = (overflow_q && !clr_err) || (wr_en && !wr_acc);
        underflow_d = (underflow_q && !clr_err) || (rd_en && !rd_acc);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; writes during reset are dropped.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data  = mem[rd_ptr_q];
            assign rd_valid = !empty;
        end else begin : g_reg
            logic [WIDTH-1:0] rd_data_q;
            logic             rd_valid_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) begin
                        rd_data_q <= mem[rd_ptr_q];
                    end
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

endmodule
